// File: rtl/quiz_round_ctrl.sv
// Buzzer-quiz round sequencer: BCD answer countdown,
// first-buzz arbitration and saturating per-player scoring.
`timescale 1ns/1ps
module quiz_round_ctrl #(
   parameter int NUSER     = 4,
   parameter int TICK_DIV  = 100000000,
   parameter int SCORE_MAX = 99
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               clr_scores,
   input  logic [NUSER-1:0]   buzz,
   input  logic               judge_ok,
   input  logic               judge_bad,
   input  logic               endset,
   input  logic [7:0]         maxtime,
   input  logic [3:0]         maxuser,
   input  logic [3:0]         scorejia,
   input  logic [3:0]         scorejian,
   output logic [7:0]         remaining,
   output logic [NUSER-1:0]   winner,
   output logic               timeout,
   output logic               busy,
   output logic [8*NUSER-1:0] score
);

   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, LOCKED, TOUT} state_t;

   state_t             state, state_n;
   logic [TW-1:0]      tcnt, tcnt_n;
   logic [7:0]         rem_n;
   logic [NUSER-1:0]   win_n;
   logic               to_n, busy_n;
   logic [8*NUSER-1:0] score_n;
   logic [NUSER-1:0]   act, abuzz, first;
   logic               tick, go;
   logic [7:0]         ld_val, dec_val;

   function automatic logic [7:0] bcd_clamp(input logic [7:0] v);
      logic [3:0] hi, lo;
      hi = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
      lo = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
      return {hi, lo};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] == 4'd0)
         return {v[7:4] - 4'd1, 4'd9};
      else
         return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [7:0] sat_add(input logic [7:0] a,
                                          input logic [3:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {5'd0, b};
      return (s > 9'(SCORE_MAX)) ? 8'(SCORE_MAX) : s[7:0];
   endfunction

   function automatic logic [7:0] floor_sub(input logic [7:0] a,
                                            input logic [3:0] b);
      return (a < {4'd0, b}) ? 8'd0 : a - {4'd0, b};
   endfunction

   always_comb begin
      act = '0;
      for (int i = 0; i < NUSER; i++)
         act[i] = (int'(maxuser) > i);
   end

   assign abuzz = buzz & act;

   // Downward scan leaves only the lowest pressed index set.
   always_comb begin
      first = '0;
      for (int i = NUSER - 1; i >= 0; i--)
         if (abuzz[i]) begin
            first    = '0;
            first[i] = 1'b1;
         end
   end

   assign tick    = (tcnt == TW'(TICK_DIV - 1));
   assign go      = start && endset;
   assign ld_val  = bcd_clamp(maxtime);
   assign dec_val = bcd_dec(remaining);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         tcnt      <= '0;
         remaining <= 8'h00;
         winner    <= '0;
         timeout   <= 1'b0;
         busy      <= 1'b0;
         score     <= '0;
      end else begin
         state     <= state_n;
         tcnt      <= tcnt_n;
         remaining <= rem_n;
         winner    <= win_n;
         timeout   <= to_n;
         busy      <= busy_n;
         score     <= score_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE, TOUT: if (go) state_n = COUNT;
         COUNT: begin
            if (|abuzz)
               state_n = LOCKED;
            else if (remaining == 8'h00)
               state_n = TOUT;
            else if (tick && dec_val == 8'h00)
               state_n = TOUT;
         end
         LOCKED: if (judge_ok ^ judge_bad) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      rem_n   = remaining;
      win_n   = winner;
      to_n    = timeout;
      tcnt_n  = '0;
      score_n = score;
      busy_n  = (state_n == COUNT) || (state_n == LOCKED);
      unique case (state)
         IDLE: begin
            rem_n = ld_val;
            to_n  = 1'b0;
            if (clr_scores) score_n = '0;
            if (go) win_n = '0;
         end
         TOUT: begin
            rem_n = 8'h00;
            win_n = '0;
            to_n  = 1'b1;
            if (clr_scores) score_n = '0;
            if (go) begin
               rem_n = ld_val;
               to_n  = 1'b0;
            end
         end
         COUNT: begin
            tcnt_n = tick ? '0 : tcnt + TW'(1);
            if (|abuzz)
               win_n = first;
            else if (remaining == 8'h00)
               to_n = 1'b1;
            else if (tick) begin
               rem_n = dec_val;
               to_n  = (dec_val == 8'h00);
            end
         end
         LOCKED: begin
            if (judge_ok ^ judge_bad)
               for (int i = 0; i < NUSER; i++)
                  if (winner[i])
                     score_n[8*i +: 8] = judge_ok
                        ? sat_add(score[8*i +: 8], scorejia)
                        : floor_sub(score[8*i +: 8], scorejian);
         end
         default: ;
      endcase
   end

endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
- Round sequencer for the responder (buzzer quiz) system.
- Consumes the settings outputs (maxtime, maxuser, scorejia, scorejian, endset) and the player buzzers.
- Runs the BCD answer countdown and arbitrates the first valid buzz.
- Applies the host's correct/wrong judgement to per-player score registers that drive the display logic.

Parameters:
- NUSER, 4: number of buzzer inputs and score registers.
- TICK_DIV, 100000000: clk cycles per countdown second (benches use small values, e.g. 10).
- SCORE_MAX, 99: saturation ceiling for binary scores.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  host start-round pulse, one cycle
- clr_scores  in  1  host clear-all-scores pulse, one cycle
- buzz  in  NUSER  player buttons, debounced level, bit i = player i
- judge_ok  in  1  host "correct" pulse
- judge_bad  in  1  host "wrong" pulse
- endset  in  1  settings finished; start ignored while 0
- maxtime  in  8  answer time, 2-digit BCD seconds
- maxuser  in  4  number of active players, binary
- scorejia  in  4  points added on correct
- scorejian  in  4  points subtracted on wrong
- remaining  out  8  BCD seconds left
- winner  out  NUSER  one-hot locked player, 0 = none
- timeout  out  1  round expired without a buzz
- busy  out  1  high in COUNT and LOCKED
- score  out  8*NUSER  packed binary scores, player i at [8i+7:8i]

Behaviour:
Reset:
- State IDLE; remaining=8'h00; winner=0; timeout=0; busy=0; all scores 0; tick counter 0.
- rst takes effect on the next clk edge and aborts any round in progress.

Active players:
- Player i is active iff i < min(maxuser, NUSER).
- Buzz bits of inactive players are always ignored.

IDLE:
- Each cycle, remaining follows maxtime (registered, 1-cycle lag), with any BCD nibble >9 clamped to 9.
- start && endset -> COUNT. On transition: remaining = clamped maxtime; tick counter=0; winner=0; timeout=0.
- clr_scores zeroes all scores. Honoured in IDLE and TIMEOUT only.

COUNT (busy=1):
- Tick counter increments each cycle. At TICK_DIV-1 it wraps to 0 and a tick fires.
- On a tick, remaining decrements in BCD: low nibble 0 -> 9 with high nibble -1; otherwise low nibble -1.
- If remaining==8'h00 on entry (maxtime 00), go to TIMEOUT the next cycle with no tick needed.
- When a tick makes remaining 8'h00 -> TIMEOUT, timeout=1.
- Any active buzz bit high -> LOCKED. winner = one-hot of the lowest-index active pressed player. remaining freezes.
- Buzz beats tick in the same cycle: lock with the pre-tick remaining value; no timeout.
- start, clr_scores, judge_* are ignored.

LOCKED (busy=1):
- remaining and winner hold.
- judge_ok alone: score[w] = min(score[w] + scorejia, SCORE_MAX) -> IDLE.
- judge_bad alone: score[w] = max(score[w] - scorejian, 0) -> IDLE.
- Both asserted in the same cycle: no score change; stay in LOCKED.
- Buzz and start are ignored.
- winner stays visible in IDLE until the next round starts.

TIMEOUT:
- timeout=1; remaining=00; winner=0.
- start && endset -> COUNT with the same load as from IDLE; timeout clears.
- judge_* ignored.

Arithmetic:
- Scores are 8-bit unsigned.
- The add is computed 9-bit before the saturation compare.
- The subtract floors at 0 with no wrap.
- Exactly one score register changes per judgement.

Timing:
- Every output is registered and changes on the clk edge after the causing input.

Test Plan:
- rst; TICK_DIV=10, maxtime=8'h03, maxuser=4, endset=1; start; no buzz -> remaining 03,02,01,00 at 10-cycle intervals; timeout=1 in the cycle remaining reaches 00; busy=0.
- start; buzz=4'b1010 at cycle 15 -> winner=4'b0010, remaining frozen at 02; judge_ok with scorejia=3 -> score[1]=3; state IDLE; winner still 0010.
- maxuser=2; buzz=4'b1000 then 4'b0100 during COUNT -> no lock; countdown continues to timeout.
- score[0]=2, scorejian=4, player 0 wins, judge_bad -> score[0]=0. score[0]=97, scorejia=5, judge_ok -> 99.
- Buzz in the same cycle as the tick taking 01 -> 00 -> LOCKED with remaining=01, timeout=0. judge_ok and judge_bad together -> no change, stays LOCKED.
- maxtime=8'h10: first tick gives 09. maxtime=8'h00 -> TIMEOUT one cycle after start. endset=0 -> start ignored. rst mid-COUNT -> all outputs back to reset values next cycle.
